// File: rtl/uart_tx_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo_pkg
// Description : Shared constants for the UART loopback path: dispatch FSM
//               state encoding, baud divisors and a width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_tx_fifo_pkg;

    localparam int c_STATE_W = 2;

    localparam logic [c_STATE_W-1:0] c_IDLE   = 2'd0;
    localparam logic [c_STATE_W-1:0] c_LAUNCH = 2'd1;
    localparam logic [c_STATE_W-1:0] c_BUSY   = 2'd2;

    // Clocks per bit at 25 MHz
    localparam int c_BAUD_115200 = 217;
    localparam int c_BAUD_9600   = 2604;

    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_fifo_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo_if
// Description : Receiver-side push, transmitter handshake and FIFO status
//               bundle for uart_tx_fifo.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_fifo_if
    import uart_tx_fifo_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
);
    localparam int c_CNT_W = count_width(DEPTH);

    logic [WIDTH-1:0]   i_rx_byte;
    logic               i_rx_valid;
    logic               i_tx_active;
    logic               i_tx_done;
    logic [WIDTH-1:0]   o_tx_byte;
    logic               o_tx_dv;
    logic [c_CNT_W-1:0] o_count;
    logic               o_empty;
    logic               o_full;
    logic               o_overflow;

    modport slave (
        input  i_rx_byte, i_rx_valid, i_tx_active, i_tx_done,
        output o_tx_byte, o_tx_dv, o_count, o_empty, o_full, o_overflow
    );

    modport master (
        output i_rx_byte, i_rx_valid, i_tx_active, i_tx_done,
        input  o_tx_byte, o_tx_dv, o_count, o_empty, o_full, o_overflow
    );

endinterface
`default_nettype wire

// File: rtl/uart_tx_fifo_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO with registered count/empty/full and a
//               sticky overflow flag for pushes dropped while full.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic                          i_push,
    input  logic [WIDTH-1:0]              i_wdata,
    input  logic                          i_pop,
    output logic [WIDTH-1:0]              o_rdata,
    output logic [count_width(DEPTH)-1:0] o_count,
    output logic                          o_empty,
    output logic                          o_full,
    output logic                          o_overflow
);
    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = count_width(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               r_empty;
    logic               r_full;
    logic               r_overflow;

    logic               w_wr_en;
    logic               w_rd_en;
    logic [c_CNT_W-1:0] w_count_nxt;

    // A pop in the same cycle frees the slot a push into a full FIFO needs
    assign w_wr_en = i_push & (~r_full | i_pop);
    assign w_rd_en = i_pop & ~r_empty;

    always_comb begin
        w_count_nxt = r_count;
        if (w_wr_en && !w_rd_en) begin
            w_count_nxt = r_count + 1'b1;
        end else if (!w_wr_en && w_rd_en) begin
            w_count_nxt = r_count - 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset && w_wr_en) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_empty    <= 1'b1;
            r_full     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (i_push && r_full && !i_pop) begin
                r_overflow <= 1'b1;
            end
            r_count <= w_count_nxt;
            r_empty <= (w_count_nxt == '0);
            r_full  <= (w_count_nxt == c_CNT_W'(DEPTH));
        end
    end

    assign o_rdata    = r_mem[r_rd_ptr];
    assign o_count    = r_count;
    assign o_empty    = r_empty;
    assign o_full     = r_full;
    assign o_overflow = r_overflow;

endmodule
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo
// Description : Buffers received bytes and launches them one at a time into
//               the UART transmitter over its dv/active/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic          i_clk,
    input  logic          i_reset,
    uart_tx_fifo_if.slave bus
);
    localparam int c_CNT_W = count_width(DEPTH);

    logic [c_STATE_W-1:0] r_state;
    logic                 r_tx_dv;
    logic [WIDTH-1:0]     r_tx_byte;

    logic                 w_can_launch;
    logic                 w_pop;
    logic [WIDTH-1:0]     w_rd_data;
    logic [c_CNT_W-1:0]   w_count;
    logic                 w_empty;
    logic                 w_full;
    logic                 w_overflow;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_fifo (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_push     (bus.i_rx_valid),
        .i_wdata    (bus.i_rx_byte),
        .i_pop      (w_pop),
        .o_rdata    (w_rd_data),
        .o_count    (w_count),
        .o_empty    (w_empty),
        .o_full     (w_full),
        .o_overflow (w_overflow)
    );

    // A done pulse with the transmitter already idle relaunches directly,
    // so back-to-back bytes do not lose a cycle passing through IDLE.
    always_comb begin
        w_can_launch = 1'b0;
        case (r_state)
            c_IDLE:           w_can_launch = 1'b1;
            c_LAUNCH, c_BUSY: w_can_launch = bus.i_tx_done;
            default:          w_can_launch = 1'b0;
        endcase
        w_pop = w_can_launch & ~w_empty & ~bus.i_tx_active;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= c_IDLE;
            r_tx_dv   <= 1'b0;
            r_tx_byte <= '0;
        end else begin
            r_tx_dv <= w_pop;
            if (w_pop) begin
                r_tx_byte <= w_rd_data;
                r_state   <= c_LAUNCH;
            end else begin
                case (r_state)
                    c_IDLE: r_state <= c_IDLE;
                    c_LAUNCH: begin
                        if (bus.i_tx_done) begin
                            r_state <= c_IDLE;
                        end else if (bus.i_tx_active) begin
                            r_state <= c_BUSY;
                        end
                    end
                    c_BUSY: begin
                        if (bus.i_tx_done || !bus.i_tx_active) begin
                            r_state <= c_IDLE;
                        end
                    end
                    default: r_state <= c_IDLE;
                endcase
            end
        end
    end

    assign bus.o_tx_byte  = r_tx_byte;
    assign bus.o_tx_dv    = r_tx_dv;
    assign bus.o_count    = w_count;
    assign bus.o_empty    = w_empty;
    assign bus.o_full     = w_full;
    assign bus.o_overflow = w_overflow;

endmodule
`default_nettype wire
